// File: rtl/dda_pkg.sv
// Shared DDA fixed-point definitions. The integrator, multiplier and sample-stream blocks all
// use these types.
//   STATE_W     : integrator state width (signed 7.20 fixed point)
//   FRAC_W      : fractional bits of the state
//   dda_state_t : signed integrator state
//   dda_byte_t  : narrowed output sample byte
package dda_pkg;

  localparam int unsigned STATE_W = 27;
  localparam int unsigned FRAC_W  = 20;

  typedef logic signed [STATE_W-1:0] dda_state_t;
  typedef logic        [7:0]         dda_byte_t;

endpackage

// File: rtl/dda_sample_stream_if.sv
// Sample-stream bus: integrator strobe and state in, decimated byte stream and status out.
//   master : the integrator/consumer side (drives en, state_in, decim, out_ready)
//   slave  : dda_sample_stream (drives out_data, out_valid, fifo_count, drop_cnt, sat_flag)
interface dda_sample_stream_if #(
  parameter int unsigned STATE_W    = 27,
  parameter int unsigned DECIM_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  import dda_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                      en;
  logic signed [STATE_W-1:0] state_in;
  logic        [DECIM_W-1:0] decim;
  dda_byte_t                 out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic        [CntW-1:0]    fifo_count;
  logic        [7:0]         drop_cnt;
  logic                      sat_flag;

  modport master (
    output en, state_in, decim, out_ready,
    input  out_data, out_valid, fifo_count, drop_cnt, sat_flag
  );

  modport slave (
    input  en, state_in, decim, out_ready,
    output out_data, out_valid, fifo_count, drop_cnt, sat_flag
  );

endinterface

// File: rtl/dda_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous active-low reset.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_wdata: write request; accepted when not full, or when full with a pop this cycle
//   i_pop          : read request; ignored while empty
//   o_rdata        : head entry; holds the last popped value while empty (0 after reset)
//   o_full, o_empty, o_count : occupancy status (0..DEPTH)
// DEPTH must be a power of 2 and at least 2 so the pointers wrap naturally.
module dda_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_pop  = i_pop && !o_empty;
  // When full, a same-cycle pop frees the slot the write lands in (wptr == rptr).
  assign w_push = i_push && (!o_full || w_pop);

  assign o_rdata = o_empty ? r_last : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked by r_last until something is written.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/dda_sample_stream.sv
// Decimates the DDA integrator state stream, narrows each kept sample to a signed byte taken
// from state_in[OUT_LSB+7:OUT_LSB] (Q3.4 by default) and buffers it in a show-ahead FIFO
// presented as a valid/ready byte port. Samples captured while the FIFO is full (and not being
// popped) are dropped and counted.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : en/state_in/decim in, out_data/out_valid/out_ready byte port,
//                    fifo_count, drop_cnt (saturating), sat_flag (sticky)
// Build option DDA_SAT_EN: clamp out-of-range samples to 0x7F/0x80 and report them on sat_flag.
// Without it the plain slice wraps and sat_flag is tied low.
module dda_sample_stream #(
  parameter int unsigned STATE_W    = 27,
  parameter int unsigned OUT_LSB    = 16,
  parameter int unsigned DECIM_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dda_sample_stream_if.slave  bus
);
  import dda_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [DECIM_W-1:0] r_dec_cnt;
  logic [7:0]         r_drop_cnt;
  logic               w_capture;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  dda_byte_t          w_slice;
  dda_byte_t          w_byte;
  logic [CntW-1:0]    w_count;
  logic               w_unused_state_lo;

  // >= rather than == so that lowering decim mid-count captures on the next strobe.
  assign w_capture = bus.en && (r_dec_cnt >= bus.decim);
  assign w_pop     = bus.out_valid && bus.out_ready;
  assign w_drop    = w_capture && w_full && !w_pop;

  assign w_slice           = bus.state_in[OUT_LSB+7:OUT_LSB];
  assign w_unused_state_lo = ^bus.state_in[OUT_LSB-1:0];

`ifdef DDA_SAT_EN
  logic [STATE_W-OUT_LSB-8:0] w_hi;
  logic                       w_ovf;
  logic                       r_sat_flag;

  // The byte is representable only if every bit from its sign bit upward agrees.
  assign w_hi   = bus.state_in[STATE_W-1:OUT_LSB+7];
  assign w_ovf  = !((&w_hi) || !(|w_hi));
  assign w_byte = !w_ovf ? w_slice : (bus.state_in[STATE_W-1] ? 8'h80 : 8'h7F);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sat_flag <= 1'b0;
    end else if (w_capture && w_ovf) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign bus.sat_flag = r_sat_flag;
`else
  logic w_unused_state_hi;

  assign w_unused_state_hi = ^bus.state_in[STATE_W-1:OUT_LSB+8];
  assign w_byte            = w_slice;
  assign bus.sat_flag      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dec_cnt <= '0;
    end else if (bus.en) begin
      // The increment cannot wrap: it only happens while r_dec_cnt < decim.
      r_dec_cnt <= w_capture ? '0 : r_dec_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  dda_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_capture),
    .i_wdata (w_byte),
    .i_pop   (bus.out_ready),
    .o_rdata (bus.out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.out_valid  = !w_empty;
  assign bus.fifo_count = w_count;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_dda_sample_stream.sv
// Self-checking bench for dda_sample_stream: directed scenarios plus a randomized run, all
// compared against a queue-based behavioural model of the sample stream.
module tb_dda_sample_stream;

  localparam int unsigned DEPTH = 4;
`ifdef DDA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dda_sample_stream_if #(.STATE_W(27), .DECIM_W(8), .FIFO_DEPTH(DEPTH)) u_if ();

  dda_sample_stream #(
    .STATE_W    (27),
    .OUT_LSB    (16),
    .DECIM_W    (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: byte queue, strobes since last capture, drop count, sticky flag.
  logic [7:0] m_q[$];
  logic [7:0] m_last;
  int         m_since;
  int         m_drops;
  bit         m_sat;

  // Integer value of the state in units of 1/16: floor(state / 2^16).
  function automatic logic [7:0] narrow(input logic [26:0] st, output bit ovf);
    int          v;
    logic [31:0] vb;
    v   = int'($signed(st)) >>> 16;
    ovf = (v > 127) || (v < -128);
    vb  = v;
    if (ovf && SAT_EN) return (v < 0) ? 8'h80 : 8'h7F;
    return vb[7:0];
  endfunction

  function automatic logic [7:0] exp_data();
    return (m_q.size() > 0) ? m_q[0] : m_last;
  endfunction

  // Drive one clock cycle and advance the model to match; returns #1 after the edge.
  task automatic cycle(input bit rst, input bit en, input logic [26:0] st, input bit rdy);
    logic [7:0] b;
    bit         ovf;
    bit         cap;
    rst_n          = !rst;
    u_if.en        = en;
    u_if.state_in  = st;
    u_if.out_ready = rdy;
    if (rst) begin
      m_q.delete();
      m_last  = 8'h00;
      m_since = 0;
      m_drops = 0;
      m_sat   = 0;
    end else begin
      cap = en && (m_since >= int'(u_if.decim));
      if (en) m_since = cap ? 0 : m_since + 1;
      if (rdy && m_q.size() > 0) m_last = m_q.pop_front();
      if (cap) begin
        b = narrow(st, ovf);
        if (ovf && SAT_EN) m_sat = 1;
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else if (m_drops < 255) m_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    u_if.decim = 8'd0;
    cycle(1, 0, '0, 0);
    cycle(1, 1, 27'h0500000, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", u_if.out_valid);
    end
    n_checks++;
    if (u_if.fifo_count !== 3'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d want 0", u_if.fifo_count);
    end
    n_checks++;
    if (u_if.out_data !== 8'h00) begin
      n_errors++; $display("FAIL reset_data: got %h want 00", u_if.out_data);
    end
    n_checks++;
    if (u_if.drop_cnt !== 8'd0 || u_if.sat_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_status: got drop=%0d sat=%b want 0/0", u_if.drop_cnt, u_if.sat_flag);
    end
  endtask

  task automatic test_basic();
    u_if.decim = 8'd0;
    cycle(0, 1, 27'h0500000, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h50) begin
      n_errors++;
      $display("FAIL basic_capture: got v=%b d=%h want v=1 d=50", u_if.out_valid, u_if.out_data);
    end
    cycle(0, 0, '0, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b0 || u_if.out_data !== 8'h50) begin
      n_errors++;
      $display("FAIL basic_pop: got v=%b d=%h want v=0 d=50", u_if.out_valid, u_if.out_data);
    end
  endtask

  task automatic test_negative();
    u_if.decim = 8'd0;
    cycle(0, 1, 27'h7B00000, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'hB0) begin
      n_errors++;
      $display("FAIL negative_data: got v=%b d=%h want v=1 d=b0", u_if.out_valid, u_if.out_data);
    end
    cycle(0, 0, '0, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL negative_pop: got v=%b want 0", u_if.out_valid);
    end
  endtask

  task automatic test_decimation();
    logic [7:0] want[3];
    want[0] = 8'h04; want[1] = 8'h08; want[2] = 8'h0C;
    u_if.decim = 8'd3;
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 1, 27'(k << 16), 0);
      n_checks++;
      if (u_if.fifo_count !== 3'(m_q.size())) begin
        n_errors++;
        $display("FAIL decim_count_%0d: got %0d want %0d", k, u_if.fifo_count, m_q.size());
      end
    end
    n_checks++;
    if (u_if.fifo_count !== 3'd3) begin
      n_errors++; $display("FAIL decim_total: got %0d want 3", u_if.fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (u_if.out_data !== want[i]) begin
        n_errors++; $display("FAIL decim_data_%0d: got %h want %h", i, u_if.out_data, want[i]);
      end
      cycle(0, 0, '0, 1);
    end
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL decim_drained: got v=%b want 0", u_if.out_valid);
    end
  endtask

  task automatic test_overflow_drop();
    u_if.decim = 8'd0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 27'((i + 1) << 20), 0);
      n_checks++;
      if (u_if.out_data !== 8'h10) begin
        n_errors++; $display("FAIL ovf_head_%0d: got %h want 10", i, u_if.out_data);
      end
    end
    n_checks++;
    if (u_if.fifo_count !== 3'd4 || u_if.drop_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL ovf_full: got count=%0d drop=%0d want 4/2", u_if.fifo_count, u_if.drop_cnt);
    end
    cycle(0, 1, 27'h0700000, 1);
    n_checks++;
    if (u_if.fifo_count !== 3'd4 || u_if.drop_cnt !== 8'd2 || u_if.out_data !== 8'h20) begin
      n_errors++;
      $display("FAIL ovf_push_pop: got count=%0d drop=%0d d=%h want 4/2/20",
               u_if.fifo_count, u_if.drop_cnt, u_if.out_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (u_if.out_data !== exp_data()) begin
        n_errors++; $display("FAIL ovf_drain_%0d: got %h want %h", i, u_if.out_data, exp_data());
      end
      cycle(0, 0, '0, 1);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] want_pos;
    logic [7:0] want_neg;
    want_pos = SAT_EN ? 8'h7F : 8'hA0;
    want_neg = SAT_EN ? 8'h80 : 8'h60;
    u_if.decim = 8'd0;
    cycle(1, 0, '0, 0);
    cycle(0, 1, 27'h0A00000, 1);
    n_checks++;
    if (u_if.out_data !== want_pos || u_if.sat_flag !== SAT_EN) begin
      n_errors++;
      $display("FAIL sat_pos: got d=%h sat=%b want d=%h sat=%b",
               u_if.out_data, u_if.sat_flag, want_pos, SAT_EN);
    end
    cycle(0, 0, '0, 1);
    cycle(0, 1, 27'h7600000, 1);
    n_checks++;
    if (u_if.out_data !== want_neg || u_if.sat_flag !== SAT_EN) begin
      n_errors++;
      $display("FAIL sat_neg: got d=%h sat=%b want d=%h sat=%b",
               u_if.out_data, u_if.sat_flag, want_neg, SAT_EN);
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_random();
    int          k;
    logic [26:0] st;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) u_if.decim = 8'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 599)) - 300;
      st = 27'(k * 65536 + int'($urandom_range(0, 65535)));
      cycle(0, $urandom_range(0, 3) != 0, st, $urandom_range(0, 1) == 1);
      n_checks++;
      if (u_if.out_data !== exp_data()) begin
        n_errors++; $display("FAIL rand_data_%0d: got %h want %h", n, u_if.out_data, exp_data());
      end
      n_checks++;
      if (u_if.out_valid !== (m_q.size() > 0) || u_if.fifo_count !== 3'(m_q.size())) begin
        n_errors++;
        $display("FAIL rand_occ_%0d: got v=%b count=%0d want count=%0d",
                 n, u_if.out_valid, u_if.fifo_count, m_q.size());
      end
      n_checks++;
      if (u_if.drop_cnt !== 8'(m_drops) || u_if.sat_flag !== m_sat) begin
        n_errors++;
        $display("FAIL rand_status_%0d: got drop=%0d sat=%b want drop=%0d sat=%b",
                 n, u_if.drop_cnt, u_if.sat_flag, m_drops, m_sat);
      end
    end
  endtask

  task automatic test_drop_saturate();
    u_if.decim = 8'd0;
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 300; i++) cycle(0, 1, 27'h0100000, 0);
    n_checks++;
    if (u_if.drop_cnt !== 8'd255 || u_if.fifo_count !== 3'd4) begin
      n_errors++;
      $display("FAIL drop_saturate: got drop=%0d count=%0d want 255/4",
               u_if.drop_cnt, u_if.fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    u_if.decim = 8'd0;
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 27'((i + 1) << 16), 0);
    cycle(0, 0, '0, 1);
    n_checks++;
    if (u_if.fifo_count !== 3'd3 || u_if.drop_cnt !== 8'd5) begin
      n_errors++;
      $display("FAIL rstmid_setup: got count=%0d drop=%0d want 3/5",
               u_if.fifo_count, u_if.drop_cnt);
    end
    u_if.decim = 8'd2;
    cycle(1, 1, 27'h0300000, 1);
    n_checks++;
    if (u_if.out_valid !== 1'b0 || u_if.fifo_count !== 3'd0 || u_if.out_data !== 8'h00 ||
        u_if.drop_cnt !== 8'd0 || u_if.sat_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_clear: got v=%b count=%0d d=%h drop=%0d sat=%b want all 0",
               u_if.out_valid, u_if.fifo_count, u_if.out_data, u_if.drop_cnt, u_if.sat_flag);
    end
    cycle(0, 1, 27'h0100000, 0);
    cycle(0, 1, 27'h0200000, 0);
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_decim_early: got v=%b want 0", u_if.out_valid);
    end
    cycle(0, 1, 27'h0300000, 0);
    n_checks++;
    if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'h30) begin
      n_errors++;
      $display("FAIL rstmid_decim_capture: got v=%b d=%h want v=1 d=30",
               u_if.out_valid, u_if.out_data);
    end
  endtask

  initial begin
    u_if.en        = 1'b0;
    u_if.state_in  = '0;
    u_if.decim     = '0;
    u_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_decimation();
    test_overflow_drop();
    test_saturation();
    test_random();
    test_drop_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dda_sample_stream.md
Name: dda_sample_stream

Overview:
- Downstream consumer of the DDA integrator state (27-bit signed 7.20 fixed point).
- Decimates the state stream by a programmable ratio and narrows each kept sample to an 8-bit signed Q3.4 byte.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte port, which feeds the pin mux or a serializer.
- Counts samples dropped on FIFO overflow.

Parameters:
- STATE_W, 27: input state width (7.20 format).
- OUT_LSB, 16: LSB of the output window. The output is state_in[OUT_LSB+7:OUT_LSB], i.e. Q3.4 with the default.
- DECIM_W, 8: width of the decimation ratio input.
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  integrator step strobe; one state update per high cycle.
- state_in  in  STATE_W  signed integrator state, valid when en=1.
- decim  in  DECIM_W  capture every (decim+1)-th en strobe.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  8  saturating count of dropped samples.
- sat_flag  out  1  sticky: a captured sample was clamped.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - dec_cnt=0, FIFO empty (out_valid=0, fifo_count=0).
  - out_data=0, drop_cnt=0, sat_flag=0.
  - Reset overrides all other activity in that cycle, including an in-flight push or pop.
- Decimation:
  - On an en=1 cycle, if dec_cnt >= decim: capture state_in and set dec_cnt to 0.
  - Otherwise dec_cnt increments.
  - The >= comparison makes lowering decim mid-count take effect at the next en.
  - decim=0 captures every en. With en=0, dec_cnt holds.
- Narrowing:
  - byte = state_in[OUT_LSB+7:OUT_LSB].
  - Overflow means bits [STATE_W-1:OUT_LSB+7] are not all equal.
  - The handling of overflow is defined under Optional Feature.
- Push: a capture pushes the byte in the same cycle it is captured.
- Empty-FIFO latency: a capture at edge N gives out_valid=1 and out_data=byte after edge N.
- FIFO (show-ahead):
  - out_data always equals the head entry. When empty, out_data holds the last popped value, or 0 after reset.
  - Pop occurs when out_valid && out_ready.
  - out_ready while empty is ignored.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Not full: both happen and the count is unchanged.
  - Full: the pop frees a slot, the push is accepted, and there is no drop.
- Full without pop: a push is discarded and drop_cnt increments, saturating at 255. FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- drop_cnt and sat_flag clear only on reset.

Optional Feature:
- Macro: DDA_SAT_EN.
- Defined:
  - An overflowing sample is clamped to 0x7F if positive (state_in MSB=0), or to 0x80 if negative.
  - sat_flag is set when a clamped sample is captured, including one that is then dropped.
- Undefined:
  - The plain bit-slice is used (two's-complement wrap).
  - sat_flag is tied to 0 and the overflow comparator is not built.

Decomposition:
- Shared package dda_pkg holds:
  - STATE_W=27, FRAC_W=20.
  - The signed fixed-point state typedef (dda_state_t).
  - The byte typedef (dda_byte_t).
- Both are shared with the integrator and multiplier blocks.
- One sub-module: dda_sync_fifo, a parameterised width/depth show-ahead FIFO with push/pop/full/empty/count.
- Decimation, narrowing and the drop counter live in dda_sample_stream.

Test Plan:
- Basic capture: reset, decim=0, out_ready=1, en=1 for one cycle, state_in=0x0500000 (5.0) -> after the next edge out_valid=1 and out_data=0x50; pop the next cycle, then out_valid=0.
- Negative value: state_in=0x7B00000 (-5.0) with decim=0 -> out_data=0xB0.
- Decimation: decim=3, en held high for 12 cycles with a ramping state_in -> exactly 3 captures, on the 4th, 8th and 12th strobes.
- Overflow and drop: out_ready=0, decim=0, 6 strobes -> fifo_count=4, drop_cnt=2, out_data=first sample throughout. Then, with the FIFO still full, push and pop in the same cycle -> count stays 4, drop_cnt stays 2.
- Saturation: state_in=0x0A00000 (10.0):
  - With DDA_SAT_EN: out_data=0x7F and sat_flag=1. Repeat with 0x7600000 (-10.0): out_data=0x80.
  - Without DDA_SAT_EN: 10.0 gives out_data=0xA0 and sat_flag=0.
- Reset mid-operation: 3 entries buffered, drop_cnt=5, rst_n=0 for one cycle coincident with a push -> all outputs 0 and the FIFO empty after that edge; decimation restarts from dec_cnt=0.
